// File: rtl/multi_acc_if.sv
// Handshake bundle between the multiplier partial-product stream, the
// accumulator, and the result writeback.
interface multi_acc_if #(
   parameter int ACC_WIDTH = 24
);
   logic                 pp_vld;
   logic [15:0]          pp_data;
   logic                 pp_last;
   logic                 pp_rdy;
   logic                 acc_clr;
   logic                 out_vld;
   logic [ACC_WIDTH-1:0] out_data;
   logic                 out_ovf;
   logic                 out_rdy;
   logic                 acc_busy;

   modport master (
      output pp_vld, pp_data, pp_last, acc_clr, out_rdy,
      input  pp_rdy, out_vld, out_data, out_ovf, acc_busy
   );

   modport slave (
      input  pp_vld, pp_data, pp_last, acc_clr, out_rdy,
      output pp_rdy, out_vld, out_data, out_ovf, acc_busy
   );
endinterface

// File: rtl/multi_acc.sv
// Saturating dot-product accumulator: sums the partial products of DOT_LEN
// multiplies and presents the clamped total on a valid/ready output register.
module multi_acc #(
   parameter int DOT_LEN   = 4,
   parameter int ACC_WIDTH = 24
) (
   input logic        clk,
   input logic        rst_n,
   multi_acc_if.slave bus
);
   localparam int CNT_W = (DOT_LEN > 1) ? $clog2(DOT_LEN) : 1;
   localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(DOT_LEN - 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_ACC  = 1'b1;

   localparam logic [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

   logic [0:0]           state;
   logic [ACC_WIDTH-1:0] acc;
   logic [CNT_W-1:0]     term_cnt;
   logic                 ovf;
   logic                 out_vld;
   logic [ACC_WIDTH-1:0] out_data;
   logic                 out_ovf;

   logic                 at_last_term;
   logic                 pp_rdy;
   logic                 accept;
   logic                 final_beat;
   logic [ACC_WIDTH:0]   sum_wide;
   logic                 beat_ovf;
   logic [ACC_WIDTH-1:0] sum;

   always_comb begin
      at_last_term = (term_cnt == LAST_TERM);
      // Stall only the final beat of a dot product while the previous result is still held.
      pp_rdy       = ~bus.acc_clr & ~(out_vld & ~bus.out_rdy & at_last_term);
      accept       = bus.pp_vld & pp_rdy;
      final_beat   = accept & bus.pp_last & at_last_term;

      sum_wide = {acc[ACC_WIDTH-1], acc}
               + {{(ACC_WIDTH+1-16){bus.pp_data[15]}}, bus.pp_data};
      beat_ovf = sum_wide[ACC_WIDTH] ^ sum_wide[ACC_WIDTH-1];
      if (!beat_ovf)
         sum = sum_wide[ACC_WIDTH-1:0];
      else if (sum_wide[ACC_WIDTH])
         sum = SAT_MIN;
      else
         sum = SAT_MAX;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         acc      <= '0;
         term_cnt <= '0;
         ovf      <= 1'b0;
         out_vld  <= 1'b0;
         out_data <= '0;
         out_ovf  <= 1'b0;
      end else begin
         if (bus.acc_clr) begin
            state    <= ST_IDLE;
            acc      <= '0;
            term_cnt <= '0;
            ovf      <= 1'b0;
         end else if (accept) begin
            if (final_beat) begin
               state    <= ST_IDLE;
               acc      <= '0;
               term_cnt <= '0;
               ovf      <= 1'b0;
            end else begin
               state <= ST_ACC;
               acc   <= sum;
               ovf   <= ovf | beat_ovf;
               if (bus.pp_last)
                  term_cnt <= term_cnt + CNT_W'(1);
            end
         end

         // A new final beat wins over the handshake so back-to-back results keep out_vld high.
         if (final_beat) begin
            out_vld  <= 1'b1;
            out_data <= sum;
            out_ovf  <= ovf | beat_ovf;
         end else if (out_vld & bus.out_rdy) begin
            out_vld <= 1'b0;
         end
      end
   end

   assign bus.pp_rdy   = pp_rdy;
   assign bus.out_vld  = out_vld;
   assign bus.out_data = out_data;
   assign bus.out_ovf  = out_ovf;
   assign bus.acc_busy = (state == ST_ACC) | out_vld;
endmodule
